// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU controller:
// the state enum, opcode constants and the datapath select encodings.
package cpu_ctrl_pkg;

  localparam int unsigned OPC_W_DEF = 6;
  localparam int unsigned STATE_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_EXEC_R   = 4'd7,
    ST_WB_R     = 4'd8,
    ST_EXEC_I   = 4'd9,
    ST_WB_I     = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12
  } state_e;

  localparam logic [OPC_W_DEF-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W_DEF-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W_DEF-1:0] OP_SW    = 6'h2B;
  localparam logic [OPC_W_DEF-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W_DEF-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W_DEF-1:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUB_B       = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational output decode for multicycle_ctrl: maps state, opcode,
// ALU zero flag and memory-complete to every datapath control strobe.
module multicycle_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 6
) (
  input  state_e           state,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_done,
  output logic             pc_we,
  output logic             ir_we,
  output logic             iord,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_we,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic             illegal
);

  logic w_op_known;

  assign w_op_known = (opcode == OPC_W'(OP_RTYPE)) || (opcode == OPC_W'(OP_LW))  ||
                      (opcode == OPC_W'(OP_SW))    || (opcode == OPC_W'(OP_BEQ)) ||
                      (opcode == OPC_W'(OP_ADDI))  || (opcode == OPC_W'(OP_J));

  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    iord       = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_B;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_re    = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_we     = mem_done;
        pc_we     = mem_done;
      end
      // Branch target is precomputed here while the opcode is decoded.
      ST_DECODE: begin
        alu_src_b = ALUB_IMM_SH2;
        if (!w_op_known) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      ST_MEM_RD: begin
        mem_re = 1'b1;
        iord   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        mem_we     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_done;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      ST_WB_R: begin
        reg_we     = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      ST_WB_I: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_we      = zero;
        instr_done = 1'b1;
      end
      ST_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: state register and next-state logic; outputs
// come from multicycle_ctrl_decode. Optional memory wait: MULTICYCLE_CTRL_MEM_WAIT_EN.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             iord,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_we,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic             illegal
);

  state_e r_state;
  state_e w_next;
  logic   r_is_sw;
  logic   w_mem_done;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign w_mem_done = mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_done         = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Load/store direction is captured in DECODE so later states never look at the opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_sw <= 1'b0;
    end else if (r_state == ST_DECODE) begin
      r_is_sw <= (opcode == OPC_W'(OP_SW));
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RST:      w_next = ST_FETCH;
      ST_FETCH:    if (w_mem_done) w_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OPC_W'(OP_RTYPE): w_next = ST_EXEC_R;
          OPC_W'(OP_LW),
          OPC_W'(OP_SW):    w_next = ST_MEM_ADDR;
          OPC_W'(OP_BEQ):   w_next = ST_BRANCH;
          OPC_W'(OP_ADDI):  w_next = ST_EXEC_I;
          OPC_W'(OP_J):     w_next = ST_JUMP;
          default:          w_next = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR: w_next = r_is_sw ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (w_mem_done) w_next = ST_MEM_WB;
      ST_MEM_WB:   w_next = ST_FETCH;
      ST_MEM_WR:   if (w_mem_done) w_next = ST_FETCH;
      ST_EXEC_R:   w_next = ST_WB_R;
      ST_WB_R:     w_next = ST_FETCH;
      ST_EXEC_I:   w_next = ST_WB_I;
      ST_WB_I:     w_next = ST_FETCH;
      ST_BRANCH:   w_next = ST_FETCH;
      ST_JUMP:     w_next = ST_FETCH;
      default:     w_next = ST_RST;
    endcase
  end

  multicycle_ctrl_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .state      (r_state),
    .opcode     (opcode),
    .zero       (zero),
    .mem_done   (w_mem_done),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .iord       (iord),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_we     (reg_we),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control state machine for the multi-cycle simple-CPU datapath. It sequences one instruction over 3–5 cycles and drives every datapath 2:1 select: register-destination (5-bit), ALU operand (32-bit) and write-back (32-bit). It also drives the PC, IR, register-file and memory write/read strobes. It sits beside the datapath, decodes the opcode from the instruction register, and takes the ALU zero flag back.

## Interface
Parameters:
- OPC_W, 6, opcode field width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPC_W  IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete
- pc_we  out  1  PC write enable
- ir_we  out  1  IR write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- reg_dst  out  1  register-destination select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = MDR
- reg_we  out  1  register-file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump address
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal  out  1  one-cycle pulse when an unknown opcode is decoded

## Operation
- States: RST, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP.
- Any output not listed for a state is 0.
- RST: entered on reset. All outputs are 0. Goes unconditionally to FETCH.
- FETCH: mem_re=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_we and pc_we equal the memory-complete condition. Advances to DECODE on that same condition.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Next state by opcode:
  - 0x00 → EXEC_R
  - 0x23 or 0x2B → MEM_ADDR
  - 0x04 → BRANCH
  - 0x08 → EXEC_I
  - 0x02 → JUMP
  - any other opcode → FETCH, with illegal=1 and instr_done=1
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_re=1, iord=1. Goes to MEM_WB when memory completes.
- MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1, instr_done=1.
- MEM_WR: mem_we=1, iord=1. instr_done is asserted when memory completes.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10.
- WB_R: reg_we=1, reg_dst=1, mem_to_reg=0, instr_done=1.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00.
- WB_I: reg_we=1, reg_dst=0, mem_to_reg=0, instr_done=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_we=zero, instr_done=1.
- JUMP: pc_src=10, pc_we=1, instr_done=1.
- Every state that asserts instr_done returns to FETCH once its memory condition (if any) is met.
- The opcode is sampled only in DECODE. The IR holds it stable from FETCH onward.

## Timing
- State is registered. Outputs are combinational decode of the state.
- pc_we (BRANCH), ir_we/pc_we (FETCH) and the memory-complete terms also depend on inputs.
- Cycles per instruction with single-cycle memory:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - illegal: 2
- Asserting rst_n low mid-instruction forces RST asynchronously. All strobes drop immediately and no partial write is issued afterwards.
- No write strobe is ever asserted in the first cycle after reset release.

## Configuration
- MULTICYCLE_CTRL_MEM_WAIT_EN defined:
  - Memory complete = mem_ready.
  - FETCH, MEM_RD and MEM_WR hold, with their strobes asserted and ir_we/pc_we/instr_done low, until mem_ready=1.
- Undefined:
  - Memory complete = 1.
  - mem_ready is ignored and every memory state lasts exactly one cycle.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - the state enum
  - the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - the alu_src_b, alu_op and pc_src encodings
- One sub-module, multicycle_ctrl_decode: purely combinational mapping from state, opcode, zero and memory-complete to the outputs. The top holds only the state register and the next-state logic.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, release → RST for one cycle with all outputs 0, then FETCH with mem_re=1, pc_we=1, ir_we=1.
- lw (opcode 0x23), mem_ready tied 1 → states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB. reg_we=1 and mem_to_reg=1 in cycle 5 only. instr_done pulses once.
- beq (0x04): zero=1 gives pc_we=1 with pc_src=01 in cycle 3; zero=0 gives pc_we=0 in cycle 3. Both cases then return to FETCH.
- With MULTICYCLE_CTRL_MEM_WAIT_EN: mem_ready low for 3 cycles during sw MEM_WR → mem_we stays 1 for 4 cycles, instr_done fires only in the mem_ready cycle.
- Opcode 0x3F → illegal=1 and instr_done=1 in DECODE, next state FETCH, reg_we/mem_we never asserted.
- rst_n dropped during EXEC_R → reg_we never asserts. After release the sequence restarts from RST → FETCH.
